uart_tx_serializer: RTL

//  UART transmit serializer. Pops bytes from the TX-side AsyncFIFO read port
//  and shifts them out on txd as start/data/parity/stop frames. Sits directly

---
 rtl/uart_tx_serializer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: fetches one byte per frame from the TX FIFO read port and
// shifts it out as start / data (LSB first) / optional parity / 1-2 stop bits on txd_o.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  input  logic                  cts_n_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  txd_o,
  output logic                  busy_o,
  output logic                  tx_done_o
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StStart  = 3'd3;
  localparam logic [2:0] StData   = 3'd4;
  localparam logic [2:0] StParity = 3'd5;
  localparam logic [2:0] StStop   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (baud_cnt_q == div_q);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    div_d      = div_q;

    unique case (state_q)
      StIdle: begin
        if (tx_en_i && !fifo_empty_i && !cts_n_i) state_d = StFetch;
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        // Frame format is frozen here so mid-frame register writes only affect the next frame
        shift_d    = fifo_rd_data_i;
        par_d      = (^fifo_rd_data_i) ^ parity_odd_i;
        par_en_d   = parity_en_i;
        stop2_d    = stop2_i;
        div_d      = baud_div_i;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = StStart;
      end
      StStart: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = StData;
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end
      StParity: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = StStop;
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BitW'(1);
          end else begin
            bit_cnt_d = '0;
            state_d   = StIdle;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state they describe
  always_comb begin
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
    busy_d  = (state_d != StIdle);
    rd_en_d = (state_d == StFetch);
    done_d  = (state_d == StStop) && (baud_cnt_d == div_d) &&
              (!stop2_d || (bit_cnt_d == BitW'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      div_q      <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      div_q      <= div_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      done_q     <= done_d;
    end
  end

  assign txd_o        = txd_q;
  assign busy_o       = busy_q;
  assign fifo_rd_en_o = rd_en_q;
  assign tx_done_o    = done_q;

endmodule
